// File: rtl/bitserial_reg_array_if.sv
// -----------------------------------------------------------------------------
// bitserial_reg_array_if
//
// Purpose:
//   Bundles the controller handshake, the host load/read port and the debug
//   state of bitserial_reg_array into a single interface.
//
// Signals:
//   Controller side: start, op, src_a_sel, src_b_sel, dst_sel
//     (master -> slave); busy, done, cout (slave -> master).
//   Host side: host_wr_en, host_wr_sel, host_wr_data, host_rd_sel
//     (master -> slave); host_rd_data (slave -> master).
//   Debug: state_dbg (slave -> master) exposes the FSM state.
//   Optional: zero (slave -> master), present only when BITSERIAL_ZERO_FLAG_EN
//     is defined.
//
// Handshake:
//   start is sampled only while busy is low.  The edge that samples start=1
//   latches the operation, and busy rises from the next cycle.  done pulses
//   for exactly one cycle when the result is complete, and busy falls in the
//   following cycle.  A start that arrives while busy is high is dropped, not
//   queued.  A host write issued while busy is high is also dropped.
//
// Macro: BITSERIAL_ZERO_FLAG_EN adds the zero output.
// -----------------------------------------------------------------------------
interface bitserial_reg_array_if #(
   parameter int WIDTH = 8,
   parameter int SELW  = 2
);
   logic             start;
   logic [2:0]       op;
   logic [SELW-1:0]  src_a_sel;
   logic [SELW-1:0]  src_b_sel;
   logic [SELW-1:0]  dst_sel;
   logic             busy;
   logic             done;
   logic             cout;
   logic             host_wr_en;
   logic [SELW-1:0]  host_wr_sel;
   logic [WIDTH-1:0] host_wr_data;
   logic [SELW-1:0]  host_rd_sel;
   logic [WIDTH-1:0] host_rd_data;
   logic [1:0]       state_dbg;
`ifdef BITSERIAL_ZERO_FLAG_EN
   logic             zero;

   modport master (
      output start, op, src_a_sel, src_b_sel, dst_sel,
      output host_wr_en, host_wr_sel, host_wr_data, host_rd_sel,
      input  busy, done, cout, host_rd_data, state_dbg, zero
   );

   modport slave (
      input  start, op, src_a_sel, src_b_sel, dst_sel,
      input  host_wr_en, host_wr_sel, host_wr_data, host_rd_sel,
      output busy, done, cout, host_rd_data, state_dbg, zero
   );
`else
   modport master (
      output start, op, src_a_sel, src_b_sel, dst_sel,
      output host_wr_en, host_wr_sel, host_wr_data, host_rd_sel,
      input  busy, done, cout, host_rd_data, state_dbg
   );

   modport slave (
      input  start, op, src_a_sel, src_b_sel, dst_sel,
      input  host_wr_en, host_wr_sel, host_wr_data, host_rd_sel,
      output busy, done, cout, host_rd_data, state_dbg
   );
`endif
endinterface

// File: rtl/bitserial_reg_array.sv
// -----------------------------------------------------------------------------
// bitserial_reg_array
//
// Purpose:
//   Holds NREGS registers of WIDTH bits each.  It computes dst = A op B one bit
//   per clock, starting at the LSB, through a single full adder that has a
//   carry flip-flop.
//
// Ports:
//   clk  - rising-edge clock.
//   rst  - asynchronous active-high reset.  It clears all registers and the
//          FSM, and aborts a running operation without a done pulse.
//   bus  - bitserial_reg_array_if.slave:
//            start/op/src_a_sel/src_b_sel/dst_sel : operation request
//            busy/done/cout                       : status
//            host_wr_en/host_wr_sel/host_wr_data  : host register load
//            host_rd_sel/host_rd_data             : combinational host read
//            state_dbg                            : FSM state (0 IDLE, 1 RUN,
//                                                   2 DONE)
//            zero (BITSERIAL_ZERO_FLAG_EN only)   : result-was-zero flag
//
// Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_A.  Codes 6 and 7 execute as
// PASS_A.
//
// Macro: BITSERIAL_ZERO_FLAG_EN enables the zero flag.
// -----------------------------------------------------------------------------
module bitserial_reg_array #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
) (
   input logic                clk,
   input logic                rst,
   bitserial_reg_array_if.slave bus
);
   localparam int SELW = $clog2(NREGS);
   localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [1:0]       state_q, state_d;
   logic [IDXW-1:0]  bit_idx_q, bit_idx_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [2:0]       op_q, op_d;
   logic [SELW-1:0]  a_sel_q, a_sel_d;
   logic [SELW-1:0]  b_sel_q, b_sel_d;
   logic [SELW-1:0]  dst_sel_q, dst_sel_d;
`ifdef BITSERIAL_ZERO_FLAG_EN
   logic             zero_q, zero_d;
`endif

   logic a_bit, b_bit, b_eff, res_bit, carry_n;

   // Bit-serial ALU.  Operands are read from the registered array, so when
   // dst aliases a source, bit i is read before it is overwritten on the same
   // edge.  Only higher, still-untouched bits are read later.
   always_comb begin
      a_bit   = regs_q[a_sel_q][bit_idx_q];
      b_bit   = regs_q[b_sel_q][bit_idx_q];
      b_eff   = (op_q == OP_SUB) ? ~b_bit : b_bit;
      res_bit = a_bit;
      carry_n = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            res_bit = a_bit ^ b_eff ^ carry_q;
            carry_n = (a_bit & b_eff) | ((a_bit ^ b_eff) & carry_q);
         end
         OP_AND:  res_bit = a_bit & b_bit;
         OP_OR:   res_bit = a_bit | b_bit;
         OP_XOR:  res_bit = a_bit ^ b_bit;
         default: res_bit = a_bit;
      endcase
   end

   always_comb begin
      regs_d    = regs_q;
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      op_d      = op_q;
      a_sel_d   = a_sel_q;
      b_sel_d   = b_sel_q;
      dst_sel_d = dst_sel_q;
`ifdef BITSERIAL_ZERO_FLAG_EN
      zero_d    = zero_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // A host write on the start edge lands before the first RUN read.
            if (bus.host_wr_en) begin
               regs_d[bus.host_wr_sel] = bus.host_wr_data;
            end
            if (bus.start) begin
               op_d      = bus.op;
               a_sel_d   = bus.src_a_sel;
               b_sel_d   = bus.src_b_sel;
               dst_sel_d = bus.dst_sel;
               bit_idx_d = '0;
               carry_d   = (bus.op == OP_SUB);  // +1 of two's complement
               state_d   = ST_RUN;
`ifdef BITSERIAL_ZERO_FLAG_EN
               zero_d    = 1'b0;
`endif
            end
         end
         ST_RUN: begin
            regs_d[dst_sel_q][bit_idx_q] = res_bit;
            carry_d = carry_n;
`ifdef BITSERIAL_ZERO_FLAG_EN
            // While RUN is active, zero accumulates "any bit set".  On exit
            // it is inverted into the flag.
            zero_d  = zero_q | res_bit;
`endif
            if (bit_idx_q == IDXW'(WIDTH - 1)) begin
               cout_d    = carry_n;
               bit_idx_d = '0;
               state_d   = ST_DONE;
`ifdef BITSERIAL_ZERO_FLAG_EN
               zero_d    = ~(zero_q | res_bit);
`endif
            end else begin
               bit_idx_d = bit_idx_q + IDXW'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q    <= '{default: '0};
         state_q   <= ST_IDLE;
         bit_idx_q <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
         op_q      <= '0;
         a_sel_q   <= '0;
         b_sel_q   <= '0;
         dst_sel_q <= '0;
`ifdef BITSERIAL_ZERO_FLAG_EN
         zero_q    <= 1'b1;
`endif
      end else begin
         regs_q    <= regs_d;
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         carry_q   <= carry_d;
         cout_q    <= cout_d;
         op_q      <= op_d;
         a_sel_q   <= a_sel_d;
         b_sel_q   <= b_sel_d;
         dst_sel_q <= dst_sel_d;
`ifdef BITSERIAL_ZERO_FLAG_EN
         zero_q    <= zero_d;
`endif
      end
   end

   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.done         = (state_q == ST_DONE);
   assign bus.cout         = cout_q;
   assign bus.host_rd_data = regs_q[bus.host_rd_sel];
   assign bus.state_dbg    = state_q;
`ifdef BITSERIAL_ZERO_FLAG_EN
   assign bus.zero         = zero_q;
`endif

endmodule

// File: tb/tb_bitserial_reg_array.sv
// -----------------------------------------------------------------------------
// tb_bitserial_reg_array
//
// Purpose: directed self-checking bench for bitserial_reg_array with
// WIDTH=8 and NREGS=4.  Each scenario task drives its stimulus and compares
// the outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_bitserial_reg_array;
   localparam int WIDTH = 8;
   localparam int NREGS = 4;
   localparam int SELW  = 2;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   bitserial_reg_array_if #(.WIDTH(WIDTH), .SELW(SELW)) bus ();

   bitserial_reg_array #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic host_write(input logic [1:0] sel, input logic [7:0] data);
      @(negedge clk);
      bus.host_wr_en   = 1'b1;
      bus.host_wr_sel  = sel;
      bus.host_wr_data = data;
      @(negedge clk);
      bus.host_wr_en   = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] sel, output logic [7:0] data);
      bus.host_rd_sel = sel;
      #1;
      data = bus.host_rd_data;
   endtask

   // Issues one operation at a negedge, so the start edge is cycle 0.  It then
   // watches cycles 1..14.  A second start is raised in cycle restart_cyc,
   // and a host write is issued in cycle wr_cyc (0 means together with
   // start).  The task returns the first done cycle (-1 if none), the number
   // of done cycles, and the number of cycles where busy differed from
   // "high in cycles 1..9".
   task automatic run_op(input logic [2:0] op, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] d,
                         input int restart_cyc, input int wr_cyc,
                         input logic [1:0] wr_sel, input logic [7:0] wr_data,
                         output int done_cyc, output int done_cnt,
                         output int busy_bad);
      done_cyc = -1;
      done_cnt = 0;
      busy_bad = 0;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.op        = op;
      bus.src_a_sel = a;
      bus.src_b_sel = b;
      bus.dst_sel   = d;
      if (wr_cyc == 0) begin
         bus.host_wr_en   = 1'b1;
         bus.host_wr_sel  = wr_sel;
         bus.host_wr_data = wr_data;
      end
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         bus.start      = 1'b0;
         bus.host_wr_en = 1'b0;
         // These changes after the start edge must not affect the operation.
         bus.src_a_sel  = 2'd3;
         bus.dst_sel    = 2'd1;
         if (k == restart_cyc) bus.start = 1'b1;
         if (k == wr_cyc) begin
            bus.host_wr_en   = 1'b1;
            bus.host_wr_sel  = wr_sel;
            bus.host_wr_data = wr_data;
         end
         #1;
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (bus.busy !== ((k >= 1) && (k <= 9))) busy_bad++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [7:0] v;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cout !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: busy=%b done=%b cout=%b expected 0 0 0",
                  bus.busy, bus.done, bus.cout);
      end
      checks++;
      if (bus.state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d expected 0", bus.state_dbg);
      end
      for (int r = 0; r < NREGS; r++) begin
         read_reg(2'(r), v);
         checks++;
         if (v !== 8'h00) begin
            errors++;
            $display("FAIL reset_reg%0d: got %h expected 00", r, v);
         end
      end
`ifdef BITSERIAL_ZERO_FLAG_EN
      checks++;
      if (bus.zero !== 1'b1) begin
         errors++;
         $display("FAIL reset_zero: got %b expected 1", bus.zero);
      end
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add();
      int dc, dn, bb;
      logic [7:0] v;
      host_write(2'd0, 8'd200);
      host_write(2'd1, 8'd100);
      run_op(3'd0, 2'd0, 2'd1, 2'd2, -1, -1, 2'd0, 8'h00, dc, dn, bb);
      read_reg(2'd2, v);
      checks++;
      if (v !== 8'd44) begin
         errors++; $display("FAIL add_result: got %0d expected 44", v);
      end
      checks++;
      if (bus.cout !== 1'b1) begin
         errors++; $display("FAIL add_cout: got %b expected 1", bus.cout);
      end
      checks++;
      if (dc !== 9 || dn !== 1) begin
         errors++;
         $display("FAIL add_done_timing: cycle=%0d count=%0d expected 9 1", dc, dn);
      end
      checks++;
      if (bb !== 0) begin
         errors++; $display("FAIL add_busy: %0d bad cycles expected 0", bb);
      end
   endtask

   task automatic test_sub();
      int dc, dn, bb;
      logic [7:0] v;
      host_write(2'd0, 8'd5);
      host_write(2'd1, 8'd7);
      run_op(3'd1, 2'd0, 2'd1, 2'd3, -1, -1, 2'd0, 8'h00, dc, dn, bb);
      read_reg(2'd3, v);
      checks++;
      if (v !== 8'hFE || bus.cout !== 1'b0) begin
         errors++;
         $display("FAIL sub_borrow: got %h cout=%b expected fe cout=0", v, bus.cout);
      end
      run_op(3'd1, 2'd1, 2'd0, 2'd3, -1, -1, 2'd0, 8'h00, dc, dn, bb);
      read_reg(2'd3, v);
      checks++;
      if (v !== 8'h02 || bus.cout !== 1'b1) begin
         errors++;
         $display("FAIL sub_noborrow: got %h cout=%b expected 02 cout=1", v, bus.cout);
      end
      checks++;
      if (dc !== 9 || dn !== 1 || bb !== 0) begin
         errors++;
         $display("FAIL sub_timing: done=%0d cnt=%0d busybad=%0d expected 9 1 0", dc, dn, bb);
      end
   endtask

   task automatic test_logic();
      int dc, dn, bb;
      logic [7:0] v;
      logic [2:0] ops [5]  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
      logic [7:0] exps [5] = '{8'h30, 8'hFC, 8'hCC, 8'hF0, 8'hF0};
      host_write(2'd0, 8'hF0);
      host_write(2'd1, 8'h3C);
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], 2'd0, 2'd1, 2'd2, -1, -1, 2'd0, 8'h00, dc, dn, bb);
         read_reg(2'd2, v);
         checks++;
         if (v !== exps[i] || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL logic_op%0d: got %h cout=%b expected %h cout=0",
                     ops[i], v, bus.cout, exps[i]);
         end
`ifdef BITSERIAL_ZERO_FLAG_EN
         checks++;
         if (bus.zero !== 1'b0) begin
            errors++; $display("FAIL logic_zero_op%0d: got %b expected 0", ops[i], bus.zero);
         end
`endif
      end
`ifdef BITSERIAL_ZERO_FLAG_EN
      host_write(2'd1, 8'h0F);
      run_op(3'd2, 2'd0, 2'd1, 2'd2, -1, -1, 2'd0, 8'h00, dc, dn, bb);
      read_reg(2'd2, v);
      checks++;
      if (v !== 8'h00 || bus.zero !== 1'b1) begin
         errors++;
         $display("FAIL zero_flag: got %h zero=%b expected 00 zero=1", v, bus.zero);
      end
`endif
   endtask

   task automatic test_alias_restart();
      int dc, dn, bb;
      logic [7:0] v;
      host_write(2'd0, 8'h55);
      run_op(3'd0, 2'd0, 2'd0, 2'd0, 4, -1, 2'd0, 8'h00, dc, dn, bb);
      read_reg(2'd0, v);
      checks++;
      if (v !== 8'hAA || bus.cout !== 1'b0) begin
         errors++;
         $display("FAIL alias_add: got %h cout=%b expected aa cout=0", v, bus.cout);
      end
      checks++;
      if (dc !== 9 || dn !== 1 || bb !== 0) begin
         errors++;
         $display("FAIL restart_ignored: done=%0d cnt=%0d busybad=%0d expected 9 1 0", dc, dn, bb);
      end
   endtask

   task automatic test_host_write();
      int dc, dn, bb;
      logic [7:0] v;
      host_write(2'd0, 8'd3);
      host_write(2'd1, 8'd4);
      run_op(3'd0, 2'd0, 2'd1, 2'd2, -1, 3, 2'd1, 8'h99, dc, dn, bb);
      read_reg(2'd1, v);
      checks++;
      if (v !== 8'd4) begin
         errors++; $display("FAIL busy_write_dropped: r1=%h expected 04", v);
      end
      read_reg(2'd2, v);
      checks++;
      if (v !== 8'd7) begin
         errors++; $display("FAIL busy_write_result: got %h expected 07", v);
      end
      run_op(3'd0, 2'd0, 2'd1, 2'd3, -1, 0, 2'd0, 8'h10, dc, dn, bb);
      read_reg(2'd3, v);
      checks++;
      if (v !== 8'h14 || bus.cout !== 1'b0) begin
         errors++;
         $display("FAIL write_with_start: got %h cout=%b expected 14 cout=0", v, bus.cout);
      end
   endtask

   task automatic test_reset_mid_run();
      int dc, dn, bb, late_done;
      logic [7:0] v;
      host_write(2'd0, 8'd200);
      host_write(2'd1, 8'd100);
      run_op(3'd0, 2'd0, 2'd1, 2'd2, -1, -1, 2'd0, 8'h00, dc, dn, bb);
      checks++;
      if (bus.cout !== 1'b1) begin
         errors++; $display("FAIL pre_abort_cout: got %b expected 1", bus.cout);
      end
      @(negedge clk);
      bus.start     = 1'b1;
      bus.op        = 3'd0;
      bus.src_a_sel = 2'd0;
      bus.src_b_sel = 2'd1;
      bus.dst_sel   = 2'd3;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cout !== 1'b0) begin
         errors++;
         $display("FAIL abort_status: busy=%b done=%b cout=%b expected 0 0 0",
                  bus.busy, bus.done, bus.cout);
      end
      for (int r = 0; r < NREGS; r++) begin
         read_reg(2'(r), v);
         checks++;
         if (v !== 8'h00) begin
            errors++; $display("FAIL abort_reg%0d: got %h expected 00", r, v);
         end
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      late_done = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.done !== 1'b0) late_done++;
      end
      checks++;
      if (late_done !== 0) begin
         errors++; $display("FAIL abort_no_done: %0d done cycles expected 0", late_done);
      end
      host_write(2'd0, 8'd1);
      host_write(2'd1, 8'd2);
      run_op(3'd0, 2'd0, 2'd1, 2'd2, -1, -1, 2'd0, 8'h00, dc, dn, bb);
      read_reg(2'd2, v);
      checks++;
      if (v !== 8'd3 || dc !== 9 || dn !== 1 || bb !== 0) begin
         errors++;
         $display("FAIL post_abort_add: got %h done=%0d cnt=%0d busybad=%0d expected 03 9 1 0",
                  v, dc, dn, bb);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks           = 0;
      errors           = 0;
      bus.start        = 1'b0;
      bus.op           = 3'd0;
      bus.src_a_sel    = 2'd0;
      bus.src_b_sel    = 2'd0;
      bus.dst_sel      = 2'd0;
      bus.host_wr_en   = 1'b0;
      bus.host_wr_sel  = 2'd0;
      bus.host_wr_data = 8'h00;
      bus.host_rd_sel  = 2'd0;
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_alias_restart();
      test_host_write();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bitserial_reg_array.md
Name: bitserial_reg_array

Overview:
- Parametrised successor to the single-bit compute register cell.
- Holds NREGS registers of WIDTH bits each and executes dst = A op B bit-serially, LSB first, one bit per clock, through a single extended full adder with a carry flip-flop.
- Start/busy/done handshake to the controller; host load/read port for register contents.
- Sits between the instruction sequencer and the in-memory register file.

Parameters:
- WIDTH, 8, bits per register; also the number of RUN cycles per operation.
- NREGS, 4, number of registers; must be >= 2.
- SELW, $clog2(NREGS), width of register select fields (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  operation request, sampled only in IDLE.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_A; 6-7 reserved, executed as PASS_A.
- src_a_sel  in  SELW  operand A register.
- src_b_sel  in  SELW  operand B register.
- dst_sel  in  SELW  destination register.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at end of operation.
- cout  out  1  final carry of last ADD/SUB; 0 after logic ops.
- host_wr_en  in  1  host write strobe.
- host_wr_sel  in  SELW  host write register.
- host_wr_data  in  WIDTH  host write data.
- host_rd_sel  in  SELW  host read register.
- host_rd_data  out  WIDTH  combinational read of selected register.

Behaviour:
- Reset (asynchronous): all registers 0, state IDLE, bit index 0, carry 0. Outputs busy=0, done=0, cout=0.
- FSM states:
  - IDLE: on start=1, latch op/src_a_sel/src_b_sel/dst_sel, set bit_idx=0, load carry (1 for SUB, else 0), go to RUN.
  - RUN: each edge writes bit bit_idx of dst with the ALU result of A[bit_idx], B'[bit_idx] and carry, updates carry, increments bit_idx. The edge that writes bit WIDTH-1 goes to DONE.
  - DONE: done=1 for exactly one cycle, cout holds the final carry, return to IDLE.
- ALU:
  - B' = ~B for SUB, else B.
  - Sum = A^B'^c; carry = A&B' | (A^B')&c for ADD/SUB.
  - For AND/OR/XOR/PASS_A the carry is forced to 0.
  - SUB cout = 1 means no borrow.
- Latency: start edge at cycle 0, done high during cycle WIDTH+1. Back-to-back starts are accepted from the cycle after DONE, so throughput is one operation per WIDTH+2 cycles.
- cout updates only on leaving RUN and is held until the next operation completes.
- start while busy: ignored, not queued.
- Operand/dst changes after the start edge have no effect (latched).
- Aliasing (dst equal to src_a and/or src_b) gives the arithmetically correct result: bit i is read and written in the same cycle, and only higher bits are read later.
- Host write:
  - Accepted only when busy=0, otherwise dropped.
  - If host_wr_en and start coincide in IDLE, the write lands on that edge and the operation uses the written value.
- host_rd_data reflects register contents including partially written dst bits during RUN.
- Reset asserted mid-RUN: immediate abort, all registers cleared, no done pulse.

Optional Feature:
- Macro BITSERIAL_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit).
  - Reset 1.
  - Cleared to 0 at the start edge, then ORed with every result bit written in RUN.
  - On leaving RUN it is set to 1 iff every written bit was 0, and held like cout.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, NREGS=4: load r0=200, r1=100; ADD r2=r0+r1 -> r2=44, cout=1, done exactly one cycle at cycle 9, busy high in cycles 1-9.
- Load r0=5, r1=7; SUB r3=r0-r1 -> r3=0xFE, cout=0. Then SUB r3=r1-r0 -> r3=2, cout=1.
- Load r0=0xF0, r1=0x3C; AND, OR, XOR into r2 -> 0x30, 0xFC, 0xCC, cout=0 each. With BITSERIAL_ZERO_FLAG_EN, AND r0 with r1=0x0F -> zero=1.
- Aliasing: r0=0x55; ADD r0=r0+r0 -> r0=0xAA, cout=0. Start asserted again in cycle 4 is ignored, with no second done.
- Host write to r1 issued while busy is dropped (r1 unchanged). Host write and start in the same IDLE cycle: the operation uses the new value.
- Assert rst in cycle 4 of RUN -> all registers 0, busy=0, done never pulses, cout=0. A new ADD after release completes normally.
